vga_sync: RTL and testbench
===========================

# vga_sync

Generates the 640x480 @ 60 Hz VGA raster timing for the display path. It divides the system clock down to a pixel-rate enable and runs horizontal and vertical pixel counters. From those counters it produces the `Posx`/`Posy` coordinates consumed by the character/blanking memory, the `hsync`/`vsync` pins and the visible-area qualifier. It is the coordinate producer that sits upstream of the memory block and the colour output stage.

## Interface
Parameters:
- `CLK_DIV`, 2: system clocks per pixel; valid range 1..15. 50 MHz Clk with 2 gives 25 MHz pixel rate.
- `H_VISIBLE`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_VISIBLE`, 480: visible lines per frame.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.

Ports:
- `Clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Posx`  out  10  current horizontal count, 0..H_TOTAL-1 (H_TOTAL = 800).
- `Posy`  out  10  current vertical count, 0..V_TOTAL-1 (V_TOTAL = 525).
- `hsync`  out  1  horizontal sync, active low.
- `vsync`  out  1  vertical sync, active low.
- `video_on`  out  1  high when Posx < H_VISIBLE and Posy < V_VISIBLE.
- `pixel_tick`  out  1  one-Clk pulse every CLK_DIV clocks; counters advance on it.
- `frame_start`  out  1  one-Clk pulse on the first Clk where the counters read (0,0).
- `frame_count`  out  8  frames completed, mod 256; only present with `VGA_FRAME_CNT_EN`.

## Operation
- **Divider.** `div` counts 0..CLK_DIV-1 and wraps. `pixel_tick` = (div == CLK_DIV-1), decoded combinationally from the registered `div`. With CLK_DIV=1, `pixel_tick` is constantly high after reset.
- **Horizontal state sequence.** On each `pixel_tick`, `Posx` increments. The states are VISIBLE (0..639), FRONT (640..655), SYNC (656..751) and BACK (752..799). Posx=799 wraps to 0.
- **Vertical advance.** `Posy` increments only on a tick where Posx wraps. The states are VISIBLE (0..479), FRONT (480..489), SYNC (490..491) and BACK (492..524). Posy=524 wraps to 0 together with Posx.
- **Sync outputs.** `hsync` is low exactly while Posx is in SYNC; `vsync` is low exactly while Posy is in SYNC. Both are registered and computed from the next-count values, so they change on the same Clk edge as Posx/Posy.
- **Visible qualifier.** `video_on` is combinational from Posx/Posy, gated low while `reset` is high.
- **Counter widths.** Both counters are 10 bits. H_TOTAL and V_TOTAL must be ≤ 1024; wrap is by compare, never by overflow.
- **Reset mid-frame.** On the next edge, the counters, divider and frame counter return to 0. `hsync`=1, `vsync`=1, `frame_start`=0, and no partial sync pulse is extended.

## Timing
- **Reset values.** Posx=0, Posy=0, hsync=1, vsync=1, video_on=0 (while reset high), pixel_tick=0, frame_start=0, frame_count=0.
- **After reset release.** The first `pixel_tick` occurs CLK_DIV Clk cycles later. Counters hold (0,0) until the Clk edge after that tick.
- **Output update.** Posx, Posy, hsync and vsync update on the Clk edge following a `pixel_tick` cycle, and then hold for CLK_DIV cycles.
- **Coherence.** All outputs are mutually coherent every cycle; there is no skew between sync and coordinates.
- **frame_start.** A single-Clk pulse, registered, asserted in the cycle right after the wrap edge 524/799 → 0/0. It is not asserted on the exit from reset.
- **Period.** Line = 800·CLK_DIV Clk; frame = 420000·CLK_DIV Clk.

## Configuration
- **`VGA_FRAME_CNT_EN` defined.** Adds the `frame_count` port, an 8-bit counter that increments on the same edge that raises `frame_start` and wraps 255 → 0. Downstream uses it for cursor blink.
- **Undefined.** The port and counter are absent; all other behaviour is identical.

## Test plan
- **Reset, CLK_DIV=2.** Hold `reset` 5 cycles, then release → Posx=0, Posy=0, hsync=1, vsync=1; first `pixel_tick` 2 Clk after release; Posx=1 one Clk after that.
- **Horizontal sync.** Run one line → hsync falls on the edge where Posx becomes 656, rises where Posx becomes 752; low for exactly 192 Clk; line period 1600 Clk.
- **Vertical sync and video_on.** Run one frame → vsync low only for Posy 490..491 (3200 Clk); video_on high only when Posx<640 and Posy<480; total 640·480·2 = 614400 video_on cycles.
- **Frame wrap.** Run to (799,524) and apply the tick → next edge gives (0,0) and `frame_start` for exactly 1 Clk. With `VGA_FRAME_CNT_EN`, frame_count goes 0→1 and wraps 255→0 after 256 frames.
- **Reset mid-sync.** Assert reset at Posx=700, Posy=491 → next edge gives Posx=0, Posy=0, hsync=1, vsync=1, no frame_start pulse.
- **CLK_DIV=1.** Run one frame → pixel_tick always high after reset; frame period exactly 420000 Clk.

Source files
------------

// File: rtl/vga_sync_if.sv
// ---------------------------------------------------------------------------
// vga_sync_if
// Bundles the raster-timing outputs of vga_sync so downstream blocks (the
// character/blanking memory and the colour output stage) can take them as one
// port.
//
// Signals:
//   Posx        [9:0]  horizontal count, 0..H_TOTAL-1
//   Posy        [9:0]  vertical count, 0..V_TOTAL-1
//   hsync              horizontal sync, active low
//   vsync              vertical sync, active low
//   video_on           visible-area qualifier
//   pixel_tick         one-Clk pulse per pixel period
//   frame_start        one-Clk pulse after the counters wrap to (0,0)
//   frame_count [7:0]  frames completed mod 256 (only with VGA_FRAME_CNT_EN)
//
// Modports: master (the timing generator drives), slave (consumers read).
// Optional feature macro: VGA_FRAME_CNT_EN
// ---------------------------------------------------------------------------
interface vga_sync_if;
    logic [9:0] Posx;
    logic [9:0] Posy;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       pixel_tick;
    logic       frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_count;
`endif

`ifdef VGA_FRAME_CNT_EN
    modport master (
        output Posx, Posy, hsync, vsync, video_on, pixel_tick, frame_start,
               frame_count
    );
    modport slave (
        input  Posx, Posy, hsync, vsync, video_on, pixel_tick, frame_start,
               frame_count
    );
`else
    modport master (
        output Posx, Posy, hsync, vsync, video_on, pixel_tick, frame_start
    );
    modport slave (
        input  Posx, Posy, hsync, vsync, video_on, pixel_tick, frame_start
    );
`endif
endinterface

// File: rtl/vga_sync.sv
// ---------------------------------------------------------------------------
// vga_sync
// VGA raster timing generator (640x480 @ 60 Hz by default). Divides Clk down
// to a pixel-rate tick, runs horizontal/vertical pixel counters and derives
// sync pulses, the visible-area qualifier and a frame-start pulse from them.
//
// Ports:
//   Clk    in   system clock, all logic on the rising edge
//   reset  in   synchronous, active-high reset
//   vga    vga_sync_if.master:
//          Posx/Posy, hsync/vsync (active low), video_on, pixel_tick,
//          frame_start and, optionally, frame_count
//
// Optional feature macro: VGA_FRAME_CNT_EN adds an 8-bit completed-frame
// counter on vga.frame_count. Without it the counter does not exist.
//
// Geometry limits: CLK_DIV in 1..15; H_TOTAL and V_TOTAL at most 1024.
// ---------------------------------------------------------------------------
module vga_sync #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic      Clk,
    input  logic      reset,
    vga_sync_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [3:0] DIV_MAX      = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_MAX        = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX        = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
    // Sync windows are held as inclusive bounds so that a porch-free
    // 1024-count geometry still fits in 10 bits.
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [3:0] r_div;
    logic [9:0] r_posx;
    logic [9:0] r_posy;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_frame_start;

    logic       w_tick;
    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_frame_wrap;
    logic [9:0] w_posx_next;
    logic [9:0] w_posy_next;

    // Tick is decoded from the registered divider; with CLK_DIV=1 the
    // divider sits at 0 and the tick is permanently true.
    assign w_tick       = (r_div == DIV_MAX);
    assign w_h_wrap     = (r_posx == H_MAX);
    assign w_v_wrap     = (r_posy == V_MAX);
    assign w_frame_wrap = w_tick && w_h_wrap && w_v_wrap;

    // Next-count values; the line counter only moves on the tick where the
    // pixel counter wraps, and wrap is always by compare.
    always_comb begin
        w_posx_next = r_posx;
        w_posy_next = r_posy;
        if (w_tick) begin
            if (w_h_wrap) begin
                w_posx_next = 10'd0;
                w_posy_next = w_v_wrap ? 10'd0 : (r_posy + 10'd1);
            end else begin
                w_posx_next = r_posx + 10'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_div         <= 4'd0;
            r_posx        <= 10'd0;
            r_posy        <= 10'd0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_tick ? 4'd0 : (r_div + 4'd1);
            r_posx        <= w_posx_next;
            r_posy        <= w_posy_next;
            // Syncs are decoded from the next counts so they land on the
            // same edge as the coordinates they describe.
            r_hsync       <= !((w_posx_next >= H_SYNC_FIRST) &&
                               (w_posx_next <= H_SYNC_LAST));
            r_vsync       <= !((w_posy_next >= V_SYNC_FIRST) &&
                               (w_posy_next <= V_SYNC_LAST));
            r_frame_start <= w_frame_wrap;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] r_frame_count;

    // Counts completed frames; advances on the edge that raises frame_start
    // and wraps naturally at 256.
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_frame_count <= 8'd0;
        end else if (w_frame_wrap) begin
            r_frame_count <= r_frame_count + 8'd1;
        end
    end

    assign vga.frame_count = r_frame_count;
`endif

    assign vga.Posx        = r_posx;
    assign vga.Posy        = r_posy;
    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
    assign vga.frame_start = r_frame_start;
    // Both qualifiers are forced low while reset is held so consumers never
    // see a stale pixel or tick during reset.
    assign vga.pixel_tick  = w_tick && !reset;
    assign vga.video_on    = !reset && (r_posx < H_VIS_END) && (r_posy < V_VIS_END);

endmodule

// File: tb/tb_vga_sync.sv
// ---------------------------------------------------------------------------
// tb_vga_sync
// Checks two vga_sync instances (CLK_DIV=2 and CLK_DIV=1) sharing one clock
// and reset, using a reduced raster so whole frames fit in a short run.
// Expected outputs come from an arithmetic model: the number of clocks since
// reset release determines the pixel index, and from that every coordinate
// and flag. The stimulus process pushes one expected record per cycle into a
// queue per DUT; an independent monitor pops and compares.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_sync;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 5, VF = 1, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;   // 15
    localparam int VT = VV + VF + VS + VB;   // 10
    localparam int FRAME = HT * VT;          // pixels per frame

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       tick;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    vga_sync_if u_if2 ();
    vga_sync_if u_if1 ();

    vga_sync #(
        .CLK_DIV(2), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) u_dut2 (
        .Clk   (clk),
        .reset (rst),
        .vga   (u_if2)
    );

    vga_sync #(
        .CLK_DIV(1), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) u_dut1 (
        .Clk   (clk),
        .reset (rst),
        .vga   (u_if1)
    );

    obs_t q2[$];
    obs_t q1[$];
    int   tests  = 0;
    int   errors = 0;
    int   t      = 0;      // clocks since the last edge that sampled reset
    bit   valid  = 0;
    bit   rst_prev = 1;

    // Reference: pixel index = clocks / CLK_DIV; coordinates are that index
    // decomposed into line and frame positions.
    function automatic obs_t model(int div, int tt, bit rst_now);
        obs_t e;
        int p     = tt / div;
        int phase = tt % div;
        int x     = p % HT;
        int y     = (p / HT) % VT;
        e.x    = 10'(x);
        e.y    = 10'(y);
        e.hs   = !(x >= HV + HF && x < HV + HF + HS);
        e.vs   = !(y >= VV + VF && y < VV + VF + VS);
        e.von  = !rst_now && (x < HV) && (y < VV);
        e.tick = !rst_now && (phase == div - 1);
        e.fs   = (p > 0) && (p % FRAME == 0) && (phase == 0);
`ifdef VGA_FRAME_CNT_EN
        e.fc   = 8'((p / FRAME) % 256);
`else
        e.fc   = 8'd0;
`endif
        return e;
    endfunction

    // One clock of stimulus: advance the model time, drive reset for the
    // coming cycle, queue what both DUTs must show during it.
    task automatic step(input bit r);
        @(negedge clk);
        if (rst_prev) begin
            t     = 0;
            valid = 1;
        end else if (valid) begin
            t = t + 1;
        end
        rst      = r;
        rst_prev = r;
        if (valid) begin
            q2.push_back(model(2, t, r));
            q1.push_back(model(1, t, r));
        end
    endtask

    task automatic run(input int n, input bit r);
        for (int i = 0; i < n; i++) step(r);
    endtask

    function automatic obs_t sample2();
        obs_t a;
        a.x = u_if2.Posx;  a.y = u_if2.Posy;
        a.hs = u_if2.hsync; a.vs = u_if2.vsync;
        a.von = u_if2.video_on; a.tick = u_if2.pixel_tick;
        a.fs = u_if2.frame_start;
`ifdef VGA_FRAME_CNT_EN
        a.fc = u_if2.frame_count;
`else
        a.fc = 8'd0;
`endif
        return a;
    endfunction

    function automatic obs_t sample1();
        obs_t a;
        a.x = u_if1.Posx;  a.y = u_if1.Posy;
        a.hs = u_if1.hsync; a.vs = u_if1.vsync;
        a.von = u_if1.video_on; a.tick = u_if1.pixel_tick;
        a.fs = u_if1.frame_start;
`ifdef VGA_FRAME_CNT_EN
        a.fc = u_if1.frame_count;
`else
        a.fc = 8'd0;
`endif
        return a;
    endfunction

    task automatic report(input string name, input int cyc, input obs_t a, input obs_t e);
        $display("FAIL %s cyc=%0d got x=%0d y=%0d hs=%0b vs=%0b von=%0b tick=%0b fs=%0b fc=%0d expected x=%0d y=%0d hs=%0b vs=%0b von=%0b tick=%0b fs=%0b fc=%0d",
                 name, cyc, a.x, a.y, a.hs, a.vs, a.von, a.tick, a.fs, a.fc,
                 e.x, e.y, e.hs, e.vs, e.von, e.tick, e.fs, e.fc);
    endtask

    // Monitor: samples mid-cycle, pops and compares; also measures the
    // frame_start spacing of the CLK_DIV=1 instance.
    int cyc = 0;
    int last_fs1 = -1;
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            while (q2.size() > 0) begin
                e = q2.pop_front();
                a = sample2();
                tests++;
                if (a !== e) begin
                    errors++;
                    report("dut2", cyc, a, e);
                end
            end
            while (q1.size() > 0) begin
                e = q1.pop_front();
                a = sample1();
                tests++;
                if (a !== e) begin
                    errors++;
                    report("dut1", cyc, a, e);
                end
            end
            if (rst) begin
                last_fs1 = -1;
            end else if (u_if1.frame_start === 1'b1) begin
                if (last_fs1 >= 0) begin
                    tests++;
                    if (cyc - last_fs1 != FRAME) begin
                        errors++;
                        $display("FAIL frame_period cyc=%0d got %0d clocks expected %0d",
                                 cyc, cyc - last_fs1, FRAME);
                    end else begin
                        $display("[TB] frame boundary cyc=%0d period=%0d", cyc, cyc - last_fs1);
                    end
                end
                last_fs1 = cyc;
            end
        end
    end

    initial begin
        obs_t m;
        bit   found;

        // Power-on reset for 5 cycles, then several free-running frames.
        run(5, 1'b1);
        $display("[TB] reset released");
        run(3 * FRAME * 2 + 37, 1'b0);

        // Reset while both syncs are active (mid hsync, last vsync line).
        found = 0;
        for (int i = 0; i < 4 * FRAME * 2 && !found; i++) begin
            m = model(2, t + 1, 1'b0);
            if (m.x == 10'(HV + HF + 1) && m.y == 10'(VV + VF + VS - 1))
                found = 1;
            else
                step(1'b0);
        end
        tests++;
        if (!found) begin
            errors++;
            $display("FAIL mid_sync_search got not-found expected found");
        end
        $display("[TB] reset inside sync at t=%0d", t + 1);
        step(1'b1);
        run(2 * FRAME * 2 + 11, 1'b0);

        // Random reset pulses of 1..3 cycles at random points.
        for (int k = 0; k < 20; k++) begin
            int gap = int'($urandom_range(1, 400));
            int len = int'($urandom_range(1, 3));
            run(gap, 1'b0);
            $display("[TB] random reset %0d after %0d clocks, %0d cycles", k, gap, len);
            run(len, 1'b1);
        end
        run(FRAME * 2 + 5, 1'b0);

`ifdef VGA_FRAME_CNT_EN
        // Long run so the CLK_DIV=2 frame counter passes 255 -> 0.
        run(258 * FRAME * 2, 1'b0);
`endif

        step(1'b0);
        repeat (3) @(negedge clk);
        #4;
        tests++;
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d/%0d entries expected 0/0", q1.size(), q2.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
